pcie_legacyint_ctrl: RTL and testbench

Sequencer for PCIe legacy (INTx) interrupt signalling. It collects level-sensitive interrupt sources, applies the per-source mask and the Command register Interrupt Disable bit, and runs the INTx virtual-wire state machine. It issues Assert_INTx and Deassert_INTx message requests to the TLP message engine over a request/acknowledge handshake. It sits between the function's interrupt sources and the message TLP generator, and drives the Status register Interrupt Status bit.

---
 rtl/pcie_legacyint_ctrl_if.sv | 24 ++
 rtl/pcie_legacyint_ctrl.sv | 75 +++++++
 tb/tb_pcie_legacyint_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_legacyint_ctrl_if.sv
// rtl/pcie_legacyint_ctrl_if.sv - interrupt source and INTx message bundle
interface pcie_legacyint_ctrl_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] irq_i;
  logic [NUM_SRC-1:0] irq_mask_i;
  logic               intx_disable_i;
  logic               msg_req_o;
  logic               msg_assert_o;
  logic               msg_ack_i;
  logic [1:0]         state_o;
  logic               intx_asserted_o;
  logic               int_status_o;

  modport slave (
    input  irq_i, irq_mask_i, intx_disable_i, msg_ack_i,
    output msg_req_o, msg_assert_o, state_o, intx_asserted_o, int_status_o
  );

  modport master (
    output irq_i, irq_mask_i, intx_disable_i, msg_ack_i,
    input  msg_req_o, msg_assert_o, state_o, intx_asserted_o, int_status_o
  );
endinterface

// File: rtl/pcie_legacyint_ctrl.sv
// rtl/pcie_legacyint_ctrl.sv - PCIe INTx virtual-wire sequencer
module pcie_legacyint_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int HOLDOFF = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pcie_legacyint_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    SEND_ASSERT   = 2'd1,
    ASSERTED      = 2'd2,
    SEND_DEASSERT = 2'd3
  } state_e;

  localparam logic [7:0] HOLDOFF_LD = 8'(HOLDOFF);

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] src_q;
  logic [7:0]         holdoff_q, holdoff_d;
  logic               pending;

  assign pending = (|src_q) & ~bus.intx_disable_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      src_q     <= '0;
      holdoff_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= bus.irq_i & ~bus.irq_mask_i;
      holdoff_q <= holdoff_d;
    end
  end

  // Requests are never retracted: only an ack leaves a SEND_* state.
  always_comb begin
    state_d   = state_q;
    holdoff_d = (holdoff_q != 8'd0) ? holdoff_q - 8'd1 : 8'd0;
    case (state_q)
      IDLE:          if (pending && holdoff_q == 8'd0) state_d = SEND_ASSERT;
      SEND_ASSERT:   if (bus.msg_ack_i) state_d = ASSERTED;
      ASSERTED:      if (!pending) state_d = SEND_DEASSERT;
      SEND_DEASSERT: if (bus.msg_ack_i) begin
        state_d   = IDLE;
        holdoff_d = HOLDOFF_LD;
      end
      default:       state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.msg_req_o       = 1'b0;
    bus.msg_assert_o    = 1'b0;
    bus.intx_asserted_o = 1'b0;
    bus.state_o         = state_q;
    bus.int_status_o    = |src_q;
    case (state_q)
      SEND_ASSERT: begin
        bus.msg_req_o    = 1'b1;
        bus.msg_assert_o = 1'b1;
      end
      ASSERTED:    bus.intx_asserted_o = 1'b1;
      SEND_DEASSERT: begin
        bus.msg_req_o       = 1'b1;
        bus.intx_asserted_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pcie_legacyint_ctrl.sv
// tb/tb_pcie_legacyint_ctrl.sv - scoreboard bench for pcie_legacyint_ctrl
module tb_pcie_legacyint_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   msg_count = 0;
  int   exp_q[$];

  pcie_legacyint_ctrl_if #(.NUM_SRC(4)) bus ();

  pcie_legacyint_ctrl #(.NUM_SRC(4), .HOLDOFF(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_req(input int budget, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.msg_req_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL %s: no msg_req_o within %0d cycles, required a request", name, budget);
    end
  endtask

  task automatic send_ack(input int delay, input string name);
    bit ok;
    int exp;
    wait_req(50, name, ok);
    if (ok) begin
      repeat (delay) @(negedge clk);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL %s: unexpected message msg_assert_o=%0b, required none", name, bus.msg_assert_o);
      end else begin
        exp = exp_q.pop_front();
        if (bus.msg_req_o !== 1'b1 || bus.msg_assert_o !== exp[0]) begin
          fails++;
          $display("FAIL %s: req=%0b msg_assert_o=%0b, required req=1 msg_assert_o=%0b",
                   name, bus.msg_req_o, bus.msg_assert_o, exp[0]);
        end
      end
      msg_count++;
      bus.msg_ack_i = 1'b1;
      @(negedge clk);
      bus.msg_ack_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.msg_req_o, bus.msg_assert_o, bus.intx_asserted_o, bus.int_status_o, bus.state_o} !== 6'b0) begin
      fails++;
      $display("FAIL reset: req=%0b asrt=%0b intx=%0b status=%0b state=%0d, required all 0",
               bus.msg_req_o, bus.msg_assert_o, bus.intx_asserted_o, bus.int_status_o, bus.state_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bus.irq_i = 4'b0001; exp_q.push_back(1);
    @(negedge clk);
    tests++;
    if (bus.int_status_o !== 1'b1 || bus.msg_req_o !== 1'b0) begin
      fails++;
      $display("FAIL single_src_q: status=%0b req=%0b, required 1 0", bus.int_status_o, bus.msg_req_o);
    end
    @(negedge clk);
    tests++;
    if (bus.msg_req_o !== 1'b1 || bus.msg_assert_o !== 1'b1 || bus.state_o !== 2'd1) begin
      fails++;
      $display("FAIL single_latency: req=%0b asrt=%0b state=%0d, required 1 1 1",
               bus.msg_req_o, bus.msg_assert_o, bus.state_o);
    end
    send_ack(2, "single_assert");
    tests++;
    if (bus.state_o !== 2'd2 || bus.intx_asserted_o !== 1'b1 || bus.msg_req_o !== 1'b0) begin
      fails++;
      $display("FAIL single_asserted: state=%0d intx=%0b req=%0b, required 2 1 0",
               bus.state_o, bus.intx_asserted_o, bus.msg_req_o);
    end
    bus.irq_i = 4'b0000; exp_q.push_back(0);
    send_ack(0, "single_deassert");
    tests++;
    if (bus.state_o !== 2'd0 || bus.intx_asserted_o !== 1'b0 || bus.int_status_o !== 1'b0) begin
      fails++;
      $display("FAIL single_idle: state=%0d intx=%0b status=%0b, required 0 0 0",
               bus.state_o, bus.intx_asserted_o, bus.int_status_o);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_mask_disable();
    bit seen;
    bus.irq_mask_i = 4'b0100; bus.irq_i = 4'b0100;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (bus.msg_req_o !== 1'b0) seen = 1'b1; end
    tests++;
    if (seen || bus.int_status_o !== 1'b0) begin
      fails++;
      $display("FAIL masked: req_seen=%0b status=%0b, required 0 0", seen, bus.int_status_o);
    end
    bus.irq_mask_i = 4'b0000; bus.intx_disable_i = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (bus.msg_req_o !== 1'b0) seen = 1'b1; end
    tests++;
    if (seen || bus.int_status_o !== 1'b1) begin
      fails++;
      $display("FAIL disabled: req_seen=%0b status=%0b, required 0 1", seen, bus.int_status_o);
    end
    bus.intx_disable_i = 1'b0; exp_q.push_back(1);
    send_ack(0, "enable_assert");
    tests++;
    if (bus.state_o !== 2'd2) begin
      fails++;
      $display("FAIL enable_asserted: state=%0d, required 2", bus.state_o);
    end
  endtask

  task automatic test_disable_asserted();
    bus.intx_disable_i = 1'b1; exp_q.push_back(0);
    send_ack(1, "disable_deassert");
    tests++;
    if (bus.intx_asserted_o !== 1'b0 || bus.int_status_o !== 1'b1 || bus.state_o !== 2'd0) begin
      fails++;
      $display("FAIL disable_idle: intx=%0b status=%0b state=%0d, required 0 1 0",
               bus.intx_asserted_o, bus.int_status_o, bus.state_o);
    end
    bus.irq_i = 4'b0000;
    @(negedge clk);
    bus.intx_disable_i = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_glitch();
    bit bad;
    bit seen;
    int start;
    start = msg_count;
    bus.irq_i = 4'b0001; exp_q.push_back(1); exp_q.push_back(0);
    @(negedge clk);
    bus.irq_i = 4'b0000;
    wait_req(10, "glitch_req", bad);
    bad = 1'b0;
    repeat (10) begin
      if (bus.msg_req_o !== 1'b1 || bus.msg_assert_o !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL glitch_hold: request dropped or type changed while unacked, required steady assert request");
    end
    send_ack(0, "glitch_assert");
    send_ack(0, "glitch_deassert");
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (bus.msg_req_o !== 1'b0) seen = 1'b1; end
    tests++;
    if (seen || msg_count - start != 2) begin
      fails++;
      $display("FAIL glitch_count: messages=%0d extra_req=%0b, required 2 0", msg_count - start, seen);
    end
  endtask

  task automatic test_holdoff();
    bit early;
    bus.irq_i = 4'b1000; exp_q.push_back(1);
    send_ack(0, "holdoff_setup_assert");
    bus.irq_i = 4'b0000; exp_q.push_back(0);
    send_ack(0, "holdoff_deassert");
    bus.irq_i = 4'b1000; exp_q.push_back(1);
    early = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      if (n > 1) @(negedge clk);
      if (n < 9 && bus.msg_req_o !== 1'b0) early = 1'b1;
    end
    @(negedge clk);
    tests++;
    if (early || bus.msg_req_o !== 1'b1 || bus.msg_assert_o !== 1'b1) begin
      fails++;
      $display("FAIL holdoff: early=%0b req_at_9=%0b asrt=%0b, required 0 1 1",
               early, bus.msg_req_o, bus.msg_assert_o);
    end
    send_ack(0, "holdoff_assert");
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int discard;
    bus.irq_i = 4'b0000; exp_q.push_back(0);
    wait_req(10, "rst_mid_req", ok);
    tests++;
    if (bus.state_o !== 2'd3) begin
      fails++;
      $display("FAIL rst_mid_state: state=%0d, required 3", bus.state_o);
    end
    rst = 1'b1;
    @(negedge clk);
    discard = exp_q.pop_front();
    tests++;
    if ({bus.msg_req_o, bus.msg_assert_o, bus.intx_asserted_o, bus.int_status_o, bus.state_o} !== 6'b0) begin
      fails++;
      $display("FAIL rst_mid_outputs: req=%0b asrt=%0b intx=%0b status=%0b state=%0d, required all 0",
               bus.msg_req_o, bus.msg_assert_o, bus.intx_asserted_o, bus.int_status_o, bus.state_o);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (bus.msg_req_o !== 1'b0) seen = 1'b1; end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL rst_mid_quiet: request after reset with no source, required none");
    end
    bus.irq_i = 4'b0010; exp_q.push_back(1);
    send_ack(0, "post_rst_assert");
    bus.irq_i = 4'b0000; exp_q.push_back(0);
    send_ack(0, "post_rst_deassert");
  endtask

  initial begin
    bus.irq_i = '0;
    bus.irq_mask_i = '0;
    bus.intx_disable_i = 1'b0;
    bus.msg_ack_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_mask_disable();
    test_disable_asserted();
    test_glitch();
    test_holdoff();
    test_reset_mid();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expected messages never seen, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
